// File: rtl/pri_pkg.sv
// ---------------------------------------------------------------------------
// pri_pkg
//   Shared definitions for the request-latch stage that feeds the 16:4
//   priority encoder: request/index widths, the latch FSM state type and a
//   one-hot decode helper.
// ---------------------------------------------------------------------------
package pri_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        OFFER  = 2'd2
    } state_e;

    // Decode a binary index into an N_REQ-bit one-hot vector.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/pri_sat_popcnt.sv
// ---------------------------------------------------------------------------
// pri_sat_popcnt
//   Adds the population count of an N_REQ-bit vector to a CNT_W-bit counter
//   value and saturates the result at all-ones.  Purely combinational; the
//   caller owns the register.
// Ports
//   vec_i      in   N_REQ   bits to count
//   cnt_i      in   CNT_W   current counter value
//   cnt_nxt_o  out  CNT_W   saturated cnt_i + popcount(vec_i)
// ---------------------------------------------------------------------------
module pri_sat_popcnt
    import pri_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [N_REQ-1:0] vec_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] cnt_nxt_o
);

    // Wide enough that cnt + N_REQ never wraps, whatever CNT_W is.
    localparam int SUM_W = CNT_W + IDX_W + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = SUM_W'(cnt_i);
        for (int i = 0; i < N_REQ; i++) begin
            sum = sum + SUM_W'(vec_i[i]);
        end
    end

    assign cnt_nxt_o = (sum > SAT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

endmodule

// File: rtl/pri_req_latch.sv
// ---------------------------------------------------------------------------
// pri_req_latch
//   Upstream stage of the 16:4 priority encoder.  Sticky-captures requests
//   into a pending register, presents pending & req_mask to the external
//   encoder, registers the returned index and offers it downstream with a
//   valid/ready handshake.  The served bit is cleared on acceptance.  Requests
//   landing on an already-pending bit are counted in a saturating counter.
//
// Configuration
//   PRI_REQ_LATCH_EDGE_EN  defined   : capture rising edges of req_in only
//                          undefined : capture req_in as a level
//
// Ports
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   req_in      in   N_REQ  request lines
//   req_mask    in   N_REQ  1 = line eligible for encoding
//   enc_vec     out  N_REQ  to encoder: pending & req_mask
//   enc_enable  out  1      to encoder: high in ENCODE only
//   enc_idx     in   IDX_W  from encoder, combinational
//   out_valid   out  1      index offered
//   out_idx     out  IDX_W  offered index
//   out_ready   in   1      downstream accept
//   pending     out  N_REQ  pending register
//   coal_cnt    out  CNT_W  saturating coalesced-request count
// ---------------------------------------------------------------------------
module pri_req_latch
    import pri_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] req_mask,
    output logic [N_REQ-1:0] enc_vec,
    output logic             enc_enable,
    input  logic [IDX_W-1:0] enc_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pending,
    output logic [CNT_W-1:0] coal_cnt
);

    state_e           state_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] coal_cnt_q, coal_cnt_d;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             enc_enable_q;

    logic [N_REQ-1:0] cap;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] masked;
    logic             handshake;

    // ---------------------------------------------------------------- capture
`ifdef PRI_REQ_LATCH_EDGE_EN
    logic [N_REQ-1:0] req_in_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_in_d <= '0;
        end else begin
            req_in_d <= req_in;
        end
    end

    assign cap = req_in & ~req_in_d;
`else
    assign cap = req_in;
`endif

    assign handshake = out_valid_q & out_ready;
    assign clr       = handshake ? onehot(out_idx_q) : '0;
    assign masked    = pending_q & req_mask;

    // cap is OR-ed after the clear so a bit re-requested while being served
    // stays pending.
    assign pending_d = (pending_q & ~clr) | cap;

    pri_sat_popcnt #(
        .CNT_W (CNT_W)
    ) u_coal (
        .vec_i     (cap & pending_q & ~clr),
        .cnt_i     (coal_cnt_q),
        .cnt_nxt_o (coal_cnt_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            coal_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            coal_cnt_q <= coal_cnt_d;
        end
    end

    // -------------------------------------------------------------------- FSM
    // Outputs are registered alongside the state, so enc_enable and out_valid
    // are set on the transition into ENCODE / OFFER respectively.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            enc_enable_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|masked) begin
                        state_q      <= ENCODE;
                        enc_enable_q <= 1'b1;
                    end
                end
                ENCODE: begin
                    enc_enable_q <= 1'b0;
                    // Mask may have dropped every eligible bit since IDLE.
                    if (|masked) begin
                        out_idx_q   <= enc_idx;
                        out_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OFFER: begin
                    // Index held regardless of new requests or mask changes.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    enc_enable_q <= 1'b0;
                    out_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign enc_vec    = masked;
    assign enc_enable = enc_enable_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign pending    = pending_q;
    assign coal_cnt   = coal_cnt_q;

endmodule
